// File: rtl/decode_stage_elastic_reg.sv
// Decode-to-execute elastic pipeline register.
// A main entry drives the _E outputs and a skid entry absorbs the one extra
// instruction that decode can send after execute stalls. ready_D comes
// straight from a flop, so there is no combinational path from ready_E
// back to ready_D. Bubbles always carry zero ALU op and zero control.
// Optional macro DECODE_STAGE_PERF_EN adds saturating stall and bubble
// counters.
module decode_stage_elastic_reg #(
  parameter int DATA_W   = 32,
  parameter int REG_ID_W = 5,
  parameter int ALU_OP_W = 4,
  parameter int CTRL_W   = 5
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                valid_D,
  output logic                ready_D,
  input  logic [DATA_W-1:0]   reg_rs_value_D,
  input  logic [DATA_W-1:0]   reg_rt_value_D,
  input  logic [DATA_W-1:0]   immediate_D,
  input  logic [REG_ID_W-1:0] reg_rs_id_D,
  input  logic [REG_ID_W-1:0] reg_rt_id_D,
  input  logic [REG_ID_W-1:0] reg_rd_id_D,
  input  logic [REG_ID_W-1:0] shamt_D,
  input  logic [ALU_OP_W-1:0] alu_op_D,
  input  logic [CTRL_W-1:0]   ctrl_D,
  output logic                valid_E,
  input  logic                ready_E,
  output logic [DATA_W-1:0]   reg_rs_value_E,
  output logic [DATA_W-1:0]   reg_rt_value_E,
  output logic [DATA_W-1:0]   immediate_E,
  output logic [REG_ID_W-1:0] reg_rs_id_E,
  output logic [REG_ID_W-1:0] reg_rt_id_E,
  output logic [REG_ID_W-1:0] reg_rd_id_E,
  output logic [REG_ID_W-1:0] shamt_E,
  output logic [ALU_OP_W-1:0] alu_op_E,
  output logic [CTRL_W-1:0]   ctrl_E
`ifdef DECODE_STAGE_PERF_EN
  ,
  output logic [31:0]         stall_count,
  output logic [31:0]         bubble_count
`endif
);

  // Payload is packed with alu_op and ctrl in the low bits so bubbles can
  // clear just that slice.
  localparam int OPS_W = ALU_OP_W + CTRL_W;
  localparam int PAY_W = 3 * DATA_W + 4 * REG_ID_W + OPS_W;

  logic [PAY_W-1:0] pay_in;
  logic [PAY_W-1:0] main_pay_q, main_pay_d;
  logic [PAY_W-1:0] skid_pay_q, skid_pay_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             accept_d;
  logic             take_e;

  assign pay_in = {reg_rs_value_D, reg_rt_value_D, immediate_D,
                   reg_rs_id_D, reg_rt_id_D, reg_rd_id_D, shamt_D,
                   alu_op_D, ctrl_D};

  assign ready_D  = ~skid_valid_q;
  assign valid_E  = main_valid_q;
  assign accept_d = valid_D & ready_D;
  assign take_e   = main_valid_q & ready_E;

  assign {reg_rs_value_E, reg_rt_value_E, immediate_E,
          reg_rs_id_E, reg_rt_id_E, reg_rd_id_E, shamt_E,
          alu_op_E, ctrl_E} = main_pay_q;

  // Next-state for main and skid entries; flush overrides every transfer.
  always_comb begin
    main_pay_d   = main_pay_q;
    skid_pay_d   = skid_pay_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d             = 1'b0;
      skid_valid_d             = 1'b0;
      main_pay_d[OPS_W-1:0]    = '0;
    end else if (!main_valid_q || take_e) begin
      if (skid_valid_q) begin
        // ready_D is low here, so decode cannot be accepting this cycle.
        main_pay_d   = skid_pay_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept_d) begin
        main_pay_d   = pay_in;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d          = 1'b0;
        main_pay_d[OPS_W-1:0] = '0;
      end
    end else if (accept_d) begin
      // Execute stalled with main full: park the new instruction in skid.
      skid_pay_d   = pay_in;
      skid_valid_d = 1'b1;
    end
  end

  // Entry storage with asynchronous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      main_pay_q   <= '0;
      skid_pay_q   <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_pay_q   <= main_pay_d;
      skid_pay_q   <= skid_pay_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

`ifdef DECODE_STAGE_PERF_EN
  // Saturating stall/bubble counters; flush does not touch them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_count  <= 32'd0;
      bubble_count <= 32'd0;
    end else begin
      if (main_valid_q && !ready_E && stall_count != 32'hFFFF_FFFF)
        stall_count <= stall_count + 32'd1;
      if (!main_valid_q && bubble_count != 32'hFFFF_FFFF)
        bubble_count <= bubble_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_stage_elastic_reg.sv
// Randomised bench for decode_stage_elastic_reg. The reference model treats
// the stage as a two-deep FIFO: accepted instructions are queued, the head is
// what execute must see, and ready_D means "fewer than two held".
module tb_decode_stage_elastic_reg;

  typedef struct packed {
    logic [31:0] rs_v;
    logic [31:0] rt_v;
    logic [31:0] imm;
    logic [4:0]  rs_id;
    logic [4:0]  rt_id;
    logic [4:0]  rd_id;
    logic [4:0]  shamt;
    logic [3:0]  alu;
    logic [4:0]  ctrl;
  } pay_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  logic valid_D = 1'b0;
  logic ready_E = 1'b0;
  pay_t pay_D = '0;
  logic ready_D, valid_E;
  logic [31:0] rs_v_E, rt_v_E, imm_E;
  logic [4:0]  rs_id_E, rt_id_E, rd_id_E, shamt_E, ctrl_E;
  logic [3:0]  alu_E;
`ifdef DECODE_STAGE_PERF_EN
  logic [31:0] stall_count, bubble_count;
  longint unsigned stall_m = 0, bubble_m = 0;
`endif

  int total = 0;
  int bad = 0;
  int n_out = 0;
  pay_t sb_q[$];

  always #5 clock = ~clock;

  decode_stage_elastic_reg dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .valid_D(valid_D), .ready_D(ready_D),
    .reg_rs_value_D(pay_D.rs_v), .reg_rt_value_D(pay_D.rt_v),
    .immediate_D(pay_D.imm), .reg_rs_id_D(pay_D.rs_id),
    .reg_rt_id_D(pay_D.rt_id), .reg_rd_id_D(pay_D.rd_id),
    .shamt_D(pay_D.shamt), .alu_op_D(pay_D.alu), .ctrl_D(pay_D.ctrl),
    .valid_E(valid_E), .ready_E(ready_E),
    .reg_rs_value_E(rs_v_E), .reg_rt_value_E(rt_v_E),
    .immediate_E(imm_E), .reg_rs_id_E(rs_id_E),
    .reg_rt_id_E(rt_id_E), .reg_rd_id_E(rd_id_E),
    .shamt_E(shamt_E), .alu_op_E(alu_E), .ctrl_E(ctrl_E)
`ifdef DECODE_STAGE_PERF_EN
    , .stall_count(stall_count), .bubble_count(bubble_count)
`endif
  );

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic pay_t out_pay();
    pay_t p;
    p = {rs_v_E, rt_v_E, imm_E, rs_id_E, rt_id_E, rd_id_E, shamt_E,
         alu_E, ctrl_E};
    return p;
  endfunction

  function automatic pay_t rand_pay();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return pay_t'(r[124:0]);
  endfunction

  // Monitor: compare DUT against the queue head, then advance the model.
  always @(negedge clock) begin
    pay_t act;
    int   held;
    act = out_pay();
    if (!reset_n) begin
      chk("rst_valid_E", 128'(valid_E), 128'(0));
      chk("rst_ready_D", 128'(ready_D), 128'(1));
      chk("rst_payload", 128'(act), 128'(0));
      sb_q.delete();
`ifdef DECODE_STAGE_PERF_EN
      stall_m = 0;
      bubble_m = 0;
      chk("rst_stall_count", 128'(stall_count), 128'(0));
      chk("rst_bubble_count", 128'(bubble_count), 128'(0));
`endif
    end else begin
      held = sb_q.size();
      chk("valid_E", 128'(valid_E), 128'(held > 0));
      chk("ready_D", 128'(ready_D), 128'(held < 2));
      if (held > 0) chk("payload", 128'(act), 128'(sb_q[0]));
      else          chk("bubble_ops", 128'({alu_E, ctrl_E}), 128'(0));
`ifdef DECODE_STAGE_PERF_EN
      chk("stall_count", 128'(stall_count), 128'(stall_m));
      chk("bubble_count", 128'(bubble_count), 128'(bubble_m));
      if (held > 0 && !ready_E && stall_m < 64'hFFFF_FFFF) stall_m++;
      if (held == 0 && bubble_m < 64'hFFFF_FFFF) bubble_m++;
`endif
      if (flush) begin
        sb_q.delete();
      end else begin
        if (held > 0 && ready_E) begin
          $display("xfer %0d rs=%h rd=%0d alu=%h ctrl=%b", n_out,
                   sb_q[0].rs_v, sb_q[0].rd_id, sb_q[0].alu, sb_q[0].ctrl);
          void'(sb_q.pop_front());
          n_out++;
        end
        if (valid_D && held < 2) sb_q.push_back(pay_D);
      end
    end
  end

  task automatic step(input logic v, input logic fl, input logic re,
                      input pay_t p);
    @(posedge clock);
    #1;
    valid_D = v;
    flush   = fl;
    ready_E = re;
    pay_D   = p;
  endtask

  initial begin
    pay_t a, b, c;
    int   start;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // Single pass with execute always ready.
    a = '0;
    a.rs_v = 32'h1234_5678;
    a.rd_id = 5'd9;
    a.ctrl = 5'b10011;
    a.alu = 4'h6;
    step(1, 0, 1, a);
    step(0, 0, 1, rand_pay());
    step(0, 0, 1, rand_pay());

    // Stall fill: A then B with execute stalled, then drain.
    a = rand_pay();
    b = rand_pay();
    step(1, 0, 0, a);
    step(1, 0, 0, b);
    repeat (3) step(1, 0, 0, rand_pay());
    repeat (4) step(0, 0, 1, rand_pay());

    // Flush with the stage full and decode offering C.
    c = rand_pay();
    step(1, 0, 0, rand_pay());
    step(1, 0, 0, rand_pay());
    step(1, 1, 0, c);
    repeat (2) step(0, 0, 1, rand_pay());
    // Flush with one held entry: the concurrent accept must be dropped.
    step(1, 0, 0, rand_pay());
    step(1, 1, 1, c);
    repeat (2) step(0, 0, 1, rand_pay());

    // Back-to-back streaming of 100 instructions.
    start = n_out;
    repeat (100) step(1, 0, 1, rand_pay());
    repeat (2) step(0, 0, 1, rand_pay());
    chk("stream_count", 128'(n_out - start), 128'(100));

    // Seven stalled cycles followed by three empty ones.
    step(1, 0, 0, rand_pay());
    repeat (7) step(0, 0, 0, rand_pay());
    step(0, 0, 1, rand_pay());
    repeat (3) step(0, 0, 1, rand_pay());

    // Asynchronous reset mid-cycle while valid_E is high.
    step(1, 0, 0, rand_pay());
    step(0, 0, 0, rand_pay());
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_valid_E", 128'(valid_E), 128'(0));
    chk("async_rst_ctrl_E", 128'(ctrl_E), 128'(0));
    chk("async_rst_payload", 128'(out_pay()), 128'(0));
    @(posedge clock);
    #1 reset_n = 1'b1;

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0),
           1'($urandom_range(0, 2) != 0), rand_pay());
    repeat (4) step(0, 0, 1, rand_pay());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage_elastic_reg.md
Name: decode_stage_elastic_reg

Overview:
- Parametrised decode-to-execute pipeline register for the next-generation pipeline.
- Replaces the fixed clear-only register with a valid/ready elastic stage, backed by a 2-entry skid buffer.
- Decode can advance while execute stalls, with no combinational ready path from execute back to decode.
- Supports synchronous flush (branch/hazard bubble) and automatically zeroes control on bubbles.

Parameters:
- DATA_W, 32, width of rs value, rt value and immediate fields
- REG_ID_W, 5, width of rs/rt/rd register ids and shamt
- ALU_OP_W, 4, width of alu_op
- CTRL_W, 5, width of packed 1-bit control bundle {reg_write, mem_to_reg, mem_write, alu_src, reg_dest}

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous flush: discards all held entries
- valid_D  in  1  decode presents an instruction
- ready_D  out  1  stage can accept an instruction; registered (= !skid_valid)
- reg_rs_value_D / reg_rt_value_D / immediate_D  in  DATA_W each  operand fields
- reg_rs_id_D / reg_rt_id_D / reg_rd_id_D / shamt_D  in  REG_ID_W each  id fields
- alu_op_D  in  ALU_OP_W  ALU operation
- ctrl_D  in  CTRL_W  control bundle
- valid_E  out  1  execute-side entry valid
- ready_E  in  1  execute consumes entry this cycle
- reg_rs_value_E … ctrl_E  out  same widths as the _D fields  registered outputs

Behaviour:
- Storage: main entry (drives _E outputs) plus skid entry, each with its own valid bit.
- Reset (reset_n low, async): both valids = 0, every _E output = 0, ready_D = 1. Reset mid-transfer discards everything.
- Transfer rules:
  - accept_D = valid_D & ready_D.
  - take_E = valid_E & ready_E.
- Latency: one cycle from accept_D to valid_E when the stage is empty.
- Per-cycle update with flush = 0:
  - Main empty or take_E, skid empty: main <= D fields if accept_D, else main valid <= 0.
  - Main empty or take_E, skid full: main <= skid, skid valid <= 0. ready_D is 0 here, so no accept.
  - Main full and !take_E: if accept_D, skid <= D fields and skid valid <= 1; main holds.
- ready_D = !skid_valid, registered. This allows one extra accept after execute stalls.
- Flush = 1 takes priority over every other event in the same cycle:
  - Both valids <= 0.
  - ctrl_E and alu_op_E <= 0; data fields don't-care.
  - An accept_D in the same cycle is dropped.
  - ready_D = 1 the next cycle.
- Bubble: whenever valid_E = 0, ctrl_E and alu_op_E are 0, so no write or store is asserted.
- Stability: while valid_E & !ready_E, all _E outputs hold exactly.
- Order: entries are delivered FIFO, never duplicated or dropped except by flush.
- Width: fields are passed through unmodified; no extension or truncation.

Optional Feature:
- Macro DECODE_STAGE_PERF_EN.
- When defined, two extra outputs are added:
  - stall_count (32 bits): increments each cycle valid_E & !ready_E.
  - bubble_count (32 bits): increments each cycle valid_E = 0 and reset_n = 1.
  - Both saturate at 0xFFFFFFFF, reset to 0 on reset_n, and are unaffected by flush.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset: assert reset_n = 0 mid-cycle with valid_E = 1 → valid_E = 0, ctrl_E = 0, all _E outputs 0 immediately, ready_D = 1 after release.
- Single pass, ready_E = 1: accept rs_value 0x1234_5678, rd_id 9, ctrl 5'b10011 at cycle N → valid_E = 1 with identical fields at N+1, valid_E = 0 at N+2.
- Stall fill: ready_E = 0, send A then B on consecutive cycles → ready_D = 0 after B, _E shows A stably. Raise ready_E → A, then B next cycle, then ready_D = 1.
- Flush priority: stage full (A main, B skid), assert flush with valid_D = 1 carrying C → next cycle valid_E = 0, ctrl_E = 0, ready_D = 1, C never appears.
- Back-to-back streaming: 100 instructions with valid_D = 1 and ready_E = 1 → one output per cycle, in order, no gaps, ready_D stays 1.
- Perf (DECODE_STAGE_PERF_EN): 7 stalled cycles, then 3 empty cycles → stall_count = 7, bubble_count ≥ 3 including the empty cycles after reset.
